ldst_unit: RTL and testbench
============================

LDST_UNIT -- requirements
Module: ldst_unit

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  access request from control FSM; sampled only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load; sampled with start.
REQ-006 addr  input  16  word address; sampled with start.
REQ-007 wdata  input  16  store data; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE and DONE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  16  registered load result; drives memData of the writeback select.
REQ-011 mem_en, mem_we  output  1 each  synchronous BRAM enable and write enable.
REQ-012 mem_addr, mem_din  output  16 each  BRAM address and write data.
REQ-013 mem_dout  input  16  BRAM read data, valid one cycle after mem_en with mem_we=0.
REQ-014 (LDST_MMIO_EN only) io_req/io_we out 1, io_addr out 8, io_wdata out 16, io_ack in 1, io_rdata in 16.

Function
REQ-015 States SHALL be IDLE, ACCESS, RDWAIT, DONE, plus IO_WAIT when MMIO is compiled in.
REQ-016 IDLE: on start=1, latch is_store/addr/wdata and go to ACCESS; otherwise stay.
REQ-017 ACCESS (RAM): mem_en=1, mem_addr=latched addr; store drives mem_we=1, mem_din=latched wdata, goes to DONE; load goes to RDWAIT.
REQ-018 RDWAIT: rdata <= mem_dout at the clock edge ending this state; go to DONE.
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-020 Latency from start edge: store done in cycle 2, load done in cycle 3; the store write commits at the edge ending ACCESS.
REQ-021 mem_en/mem_we SHALL be 0 outside ACCESS; mem_addr/mem_din hold latched values in all states.
REQ-022 start outside IDLE SHALL be ignored, with no queuing; start in DONE is also dropped.
REQ-023 rdata changes only on a completed load; stores and aborted loads leave it unchanged.
REQ-024 Address arithmetic: none; 16-bit word addressing, no alignment checks, no wrap logic.

Reset
REQ-025 While rst_n=0: state IDLE, busy=0, done=0, mem_en=0, mem_we=0, rdata=0, and latched regs are 0; io_req=0 when present.
REQ-026 Reset mid-access SHALL abort immediately; mem_we/io_req drop asynchronously, and no done is produced.

Configuration
REQ-027 Macro LDST_MMIO_EN: when defined, addr[15:8]==8'hFF in ACCESS routes to IO_WAIT instead of RAM, with mem_en=0.
REQ-028 IO_WAIT behaviour:
- io_req=1, io_we=latched is_store, io_addr=addr[7:0], io_wdata=latched wdata, all held stable until io_ack=1.
- On io_ack: a load captures io_rdata into rdata; go to DONE.
- No timeout.
REQ-029 When undefined: I/O ports absent, IO_WAIT absent, and all addresses including 0xFF00-0xFFFF go to RAM.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the state encodings, data/address width constant (16), and MMIO page constant (8'hFF).
REQ-031 No sub-module; single FSM with a registered datapath.

Verification
REQ-032 Store: start, is_store=1, addr=0x0010, wdata=0xBEEF -> mem_we=1 with mem_addr=0x0010 for one cycle; done in cycle 2; rdata unchanged.
REQ-033 Load: after REQ-032, load addr=0x0010 -> mem_en one cycle, done in cycle 3, rdata=0xBEEF held until next load.
REQ-034 Busy drop: start pulsed every cycle during a load -> exactly one access and one done; next access only after IDLE.
REQ-035 Reset abort: rst_n low in ACCESS of a store -> mem_we=0 asynchronously, no done, rdata=0, IDLE after release.
REQ-036 (LDST_MMIO_EN) Load addr=0xFF04 with io_ack delayed 4 cycles, io_rdata=0x1234 -> io_req held 4 cycles, io_addr=0x04, mem_en=0, rdata=0x1234, then done.
REQ-037 (LDST_MMIO_EN undefined) Store addr=0xFF04 -> RAM write at 0xFF04, done in cycle 2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store FSM encodings, datapath width and the MMIO page.
// The IO_WAIT encoding exists only when LDST_MMIO_EN is defined.
package cpu_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam logic [7:0]  MMIO_PAGE = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_RDWAIT  = 3'd2,
`ifdef LDST_MMIO_EN
    S_DONE    = 3'd3,
    S_IO_WAIT = 3'd4
`else
    S_DONE    = 3'd3
`endif
  } ldst_state_e;

  function automatic logic is_mmio_page(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:ADDR_W-8] == MMIO_PAGE;
  endfunction

endpackage

// File: rtl/ldst_unit.sv
// Load/store unit: one access per start, single FSM with a registered datapath.
// Optional memory-mapped I/O page routing is compiled in with LDST_MMIO_EN.
module ldst_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
`ifdef LDST_MMIO_EN
  output logic              io_req,
  output logic              io_we,
  output logic [7:0]        io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic              io_ack,
  input  logic [DATA_W-1:0] io_rdata,
`endif
  output ldst_state_e       dbg_state
);

  // start is a request level, not a valid/ready handshake: it is sampled only
  // in IDLE and dropped in every other state; done pulses once per accepted start.
  ldst_state_e       state_q;
  logic              store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;
  logic              done_q;
  logic              mem_en_q;
  logic              mem_we_q;
`ifdef LDST_MMIO_EN
  logic              io_req_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
`ifdef LDST_MMIO_EN
      io_req_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            store_q <= is_store;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            state_q <= S_ACCESS;
            // Enables are registered one state early so they line up with ACCESS.
`ifdef LDST_MMIO_EN
            mem_en_q <= !is_mmio_page(addr);
            mem_we_q <= is_store && !is_mmio_page(addr);
`else
            mem_en_q <= 1'b1;
            mem_we_q <= is_store;
`endif
          end
        end
        S_ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
`ifdef LDST_MMIO_EN
          if (is_mmio_page(addr_q)) begin
            io_req_q <= 1'b1;
            state_q  <= S_IO_WAIT;
          end else
`endif
          if (store_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          rdata_q <= mem_dout;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
`ifdef LDST_MMIO_EN
        S_IO_WAIT: begin
          if (io_ack) begin
            if (!store_q) begin
              rdata_q <= io_rdata;
            end
            io_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;
  assign dbg_state = state_q;

`ifdef LDST_MMIO_EN
  assign io_req   = io_req_q;
  assign io_we    = store_q;
  assign io_addr  = addr_q[7:0];
  assign io_wdata = wdata_q;
`endif

endmodule

// File: tb/tb_ldst_unit.sv
// Directed bench for ldst_unit with a behavioural BRAM (and an I/O responder when
// LDST_MMIO_EN is defined); expected values are hand-computed per vector.
module tb_ldst_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  ldst_state_e dbg_state;
`ifdef LDST_MMIO_EN
  logic        io_req;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata;
  logic        io_ack;
  logic [15:0] io_rdata;
  int          io_cnt;
`endif

  logic [15:0] ram [0:65535];
  logic [15:0] exp_q[$];
  int n_checks;
  int n_errors;

  ldst_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
`ifdef LDST_MMIO_EN
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_ack    (io_ack),
    .io_rdata  (io_rdata),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // read-first synchronous BRAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

`ifdef LDST_MMIO_EN
  // acknowledges during the fourth cycle of io_req
  always @(negedge clk) begin
    if (io_req) begin
      io_cnt = io_cnt + 1;
      io_ack = (io_cnt == 4);
    end else begin
      io_cnt = 0;
      io_ack = 1'b0;
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request and observe 8 cycles; start stays high through cycle 'hold'.
  task automatic run_op(input logic st, input logic [15:0] a, input logic [15:0] d,
                        input int hold, output int done_cyc, output int n_done,
                        output int n_en, output int n_we, output int n_io);
    @(negedge clk);
    start = 1'b1; is_store = st; addr = a; wdata = d;
    @(posedge clk);
    done_cyc = 0; n_done = 0; n_en = 0; n_we = 0; n_io = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k > hold) start = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (mem_en) n_en++;
      if (mem_we) n_we++;
`ifdef LDST_MMIO_EN
      if (io_req) n_io++;
`endif
    end
  endtask

  int dc, nd, ne, nw, ni;
  logic [15:0] exp_v;

  initial begin
    n_checks = 0; n_errors = 0;
    start = 0; is_store = 0; addr = '0; wdata = '0; mem_dout = '0;
    ram[16'h0010] = '0; ram[16'h0020] = '0; ram[16'h0030] = '0; ram[16'hFF04] = '0;
`ifdef LDST_MMIO_EN
    io_ack = 0; io_rdata = 16'h1234; io_cnt = 0;
`endif
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1;
    @(negedge clk);

    // store 0x0010 <- BEEF, cycle-by-cycle
    start = 1; is_store = 1; addr = 16'h0010; wdata = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    check("st_c1_en", mem_en, 1);
    check("st_c1_we", mem_we, 1);
    check("st_c1_addr", mem_addr, 16'h0010);
    check("st_c1_din", mem_din, 16'hBEEF);
    check("st_c1_busy", busy, 1);
    check("st_c1_done", done, 0);
    @(negedge clk);
    check("st_c2_done", done, 1);
    check("st_c2_busy", busy, 0);
    check("st_c2_we", mem_we, 0);
    check("st_c2_rdata", rdata, 0);
    check("st_ram", ram[16'h0010], 16'hBEEF);
    @(negedge clk);
    check("st_c3_done", done, 0);

    // load 0x0010, start held through DONE: one access, one done
    exp_q.push_back(16'hBEEF);
    run_op(0, 16'h0010, 16'h0000, 3, dc, nd, ne, nw, ni);
    exp_v = exp_q.pop_front();
    check("ld_done_cyc", dc, 3);
    check("ld_n_done", nd, 1);
    check("ld_n_en", ne, 1);
    check("ld_n_we", nw, 0);
    check("ld_rdata", rdata, exp_v);

    // store leaves rdata alone; load after IDLE gives a second access
    run_op(1, 16'h0030, 16'h5A5A, 0, dc, nd, ne, nw, ni);
    check("st2_done_cyc", dc, 2);
    check("st2_n_we", nw, 1);
    check("st2_rdata_kept", rdata, 16'hBEEF);
    exp_q.push_back(16'h5A5A);
    run_op(0, 16'h0030, 16'h0000, 0, dc, nd, ne, nw, ni);
    exp_v = exp_q.pop_front();
    check("ld2_done_cyc", dc, 3);
    check("ld2_rdata", rdata, exp_v);

    // reset during ACCESS of a store
    @(negedge clk);
    start = 1; is_store = 1; addr = 16'h0020; wdata = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    check("ab_pre_we", mem_we, 1);
    #2 rst_n = 0;
    #1;
    check("ab_we", mem_we, 0);
    check("ab_en", mem_en, 0);
    check("ab_busy", busy, 0);
    check("ab_rdata", rdata, 0);
    check("ab_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst_n = 1;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("ab_n_done", nd, 0);
    check("ab_ram", ram[16'h0020], 0);
    check("ab_state_idle", dbg_state, S_IDLE);

`ifdef LDST_MMIO_EN
    // I/O load with ack in the fourth request cycle
    run_op(0, 16'hFF04, 16'h0000, 0, dc, nd, ne, nw, ni);
    check("io_n_req", ni, 4);
    check("io_n_en", ne, 0);
    check("io_addr", io_addr, 8'h04);
    check("io_we", io_we, 0);
    check("io_rdata", rdata, 16'h1234);
    check("io_done_cyc", dc, 6);
    check("io_n_done", nd, 1);
`else
    // 0xFF04 is ordinary RAM without MMIO
    run_op(1, 16'hFF04, 16'hCAFE, 0, dc, nd, ne, nw, ni);
    check("ff_done_cyc", dc, 2);
    check("ff_n_we", nw, 1);
    check("ff_ram", ram[16'hFF04], 16'hCAFE);
    check("ff_rdata_kept", rdata, 0);
    exp_q.push_back(16'hCAFE);
    run_op(0, 16'hFF04, 16'h0000, 0, dc, nd, ne, nw, ni);
    exp_v = exp_q.pop_front();
    check("ff_ld_rdata", rdata, exp_v);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
